// File: rtl/multi_cycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and its datapath.
// Latency: none (wires only).
// Backpressure: MemReady from the datapath side can stall the sequencer in MEM.
//
// master: sequencer side (reads Opcode/Zero/MemReady, drives enables and trace).
// slave : datapath side (drives Opcode/Zero/MemReady, reads enables and trace).
interface multi_cycle_ctrl_if;
    logic [5:0] Opcode;   // IR[31:26], stable from negedge of IF to next IF
    logic       Zero;     // ALU zero flag
    logic       MemReady; // data-memory ready
    logic       PCWre;    // PC write enable
    logic       IRWre;    // IR write enable
    logic       DRWre;    // data register write enable
    logic       RegWre;   // register-file write enable
    logic       MemRd;    // data-memory read strobe
    logic       MemWr;    // data-memory write strobe
    logic       WrSel;    // write-back source: 0 = ALU, 1 = DR
    logic [1:0] PCSrc;    // 0 = PC+4, 1 = branch target, 2 = jump target
    logic [2:0] State;    // current state code
    logic       Halted;   // high while halted

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWre, IRWre, DRWre, RegWre, MemRd, MemWr, WrSel, PCSrc, State, Halted
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWre, IRWre, DRWre, RegWre, MemRd, MemWr, WrSel, PCSrc, State, Halted
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Moore sequencer walking each instruction through IF/ID/EXE/MEM/WB.
// Latency: ALU 4, LW 5, SW 4, BEQ/BNE 3, J 2, unknown (NOP) 2 cycles.
// Backpressure: with CTRL_MEM_WAIT_EN defined, MEM holds while MemReady=0.
//
// Ports: CLK (state advances on posedge), RST (async, active low),
//        bus (multi_cycle_ctrl_if.master: Opcode/Zero/MemReady in; enables, PCSrc,
//        WrSel, State and Halted out).
// Optional feature macro: CTRL_MEM_WAIT_EN (MEM wait states on MemReady=0).
module multi_cycle_ctrl (
    input  logic               CLK,
    input  logic               RST,
    multi_cycle_ctrl_if.master bus
);

    localparam logic [5:0] OP_ALU  = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'd0,
        S_ID     = 3'd1,
        S_EXE_AL = 3'd2,
        S_EXE_BR = 3'd3,
        S_EXE_LS = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t state;
    // Cleared by reset; set on the first clock edge after release. Keeps every
    // output at 0 while reset is asserted and makes the first IF fall in the
    // cycle after RST rises rather than during reset.
    logic   active;

    logic is_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_halt, is_known;
    logic mem_done;

    assign is_alu   = (bus.Opcode == OP_ALU);
    assign is_lw    = (bus.Opcode == OP_LW);
    assign is_sw    = (bus.Opcode == OP_SW);
    assign is_beq   = (bus.Opcode == OP_BEQ);
    assign is_bne   = (bus.Opcode == OP_BNE);
    assign is_j     = (bus.Opcode == OP_J);
    assign is_halt  = (bus.Opcode == OP_HALT);
    assign is_known = is_alu | is_lw | is_sw | is_beq | is_bne | is_j | is_halt;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_done = bus.MemReady;
`else
    // MEM is always a single cycle; MemReady is deliberately not observed.
    logic unused_mem_ready;
    assign unused_mem_ready = bus.MemReady;
    assign mem_done         = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IF;
            active <= 1'b0;
        end else if (!active) begin
            active <= 1'b1;
        end else begin
            case (state)
                S_IF: state <= S_ID;
                S_ID: begin
                    if (is_alu)               state <= S_EXE_AL;
                    else if (is_beq | is_bne) state <= S_EXE_BR;
                    else if (is_lw | is_sw)   state <= S_EXE_LS;
                    else if (is_halt)         state <= S_HALT;
                    else                      state <= S_IF; // J and unknown opcodes
                end
                S_EXE_AL: state <= S_WB;
                S_EXE_BR: state <= S_IF;
                S_EXE_LS: state <= S_MEM;
                S_MEM: begin
                    if (mem_done) state <= is_lw ? S_WB : S_IF;
                end
                S_WB:     state <= S_IF;
                S_HALT:   state <= S_HALT;
                default:  state <= S_IF;
            endcase
        end
    end

    // Outputs are decoded from the registered state. The branch outcome (Zero)
    // and memory completion (MemReady) only become known within the cycle, so
    // they are qualified combinationally; Opcode is stable for the whole
    // instruction. Gating by 'active' makes reset drop every enable at once.
    logic       pc_wre, ir_wre, dr_wre, reg_wre, mem_rd, mem_wr, wr_sel, halted;
    logic [1:0] pc_src;

    always_comb begin
        pc_wre  = 1'b0;
        ir_wre  = 1'b0;
        dr_wre  = 1'b0;
        reg_wre = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        wr_sel  = 1'b0;
        halted  = 1'b0;
        pc_src  = 2'd0;
        if (active) begin
            case (state)
                S_IF: ir_wre = 1'b1;
                S_ID: begin
                    if (is_j) begin
                        pc_wre = 1'b1;
                        pc_src = 2'd2;
                    end else if (!is_known) begin
                        pc_wre = 1'b1; // unknown opcode retires as a NOP
                    end
                end
                S_EXE_BR: begin
                    pc_wre = 1'b1;
                    pc_src = ((is_beq & bus.Zero) | (is_bne & ~bus.Zero)) ? 2'd1 : 2'd0;
                end
                S_MEM: begin
                    mem_rd = is_lw;
                    mem_wr = is_sw;
                    dr_wre = is_lw & mem_done;
                    pc_wre = is_sw & mem_done; // SW retires here; LW retires in WB
                end
                S_WB: begin
                    reg_wre = 1'b1;
                    pc_wre  = 1'b1;
                    wr_sel  = is_lw;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.PCWre  = pc_wre;
    assign bus.IRWre  = ir_wre;
    assign bus.DRWre  = dr_wre;
    assign bus.RegWre = reg_wre;
    assign bus.MemRd  = mem_rd;
    assign bus.MemWr  = mem_wr;
    assign bus.WrSel  = wr_sel;
    assign bus.PCSrc  = pc_src;
    assign bus.Halted = halted;
    assign bus.State  = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench for multi_cycle_ctrl: table-driven instruction rows, a randomized
// instruction stream against a trace model, and hand sequences for reset,
// HALT and MEM wait states.
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_ALU  = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Output vector: {State[2:0], PCWre, IRWre, DRWre, RegWre, MemRd, MemWr, WrSel, PCSrc[1:0], Halted}
    function automatic logic [12:0] get_out();
        return {bus.State, bus.PCWre, bus.IRWre, bus.DRWre, bus.RegWre,
                bus.MemRd, bus.MemWr, bus.WrSel, bus.PCSrc, bus.Halted};
    endfunction

    function automatic logic [12:0] mk(input logic [2:0] st, input logic pcw, input logic irw,
                                       input logic drw, input logic regw, input logic mrd,
                                       input logic mwr, input logic wsel, input logic [1:0] psrc,
                                       input logic hlt);
        return {st, pcw, irw, drw, regw, mrd, mwr, wsel, psrc, hlt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Reference trace: one entry per cycle of the instruction, from the
    // per-state output rules and the per-class state walk.
    logic [12:0] exp_q[$];

    task automatic build(input logic [5:0] op, input logic z, input int waits);
        int nmem;
`ifdef CTRL_MEM_WAIT_EN
        nmem = waits + 1;
`else
        nmem = 1;
`endif
        exp_q.delete();
        exp_q.push_back(mk(3'd0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 0));            // IF
        if (op == OP_J) begin
            exp_q.push_back(mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 2'd2, 0));
        end else if (op != OP_ALU && op != OP_LW && op != OP_SW && op != OP_BEQ &&
                     op != OP_BNE && op != OP_HALT) begin
            exp_q.push_back(mk(3'd1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0));        // NOP
        end else begin
            exp_q.push_back(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));        // plain ID
            case (op)
                OP_ALU: begin
                    exp_q.push_back(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
                    exp_q.push_back(mk(3'd6, 1, 0, 0, 1, 0, 0, 0, 2'd0, 0));
                end
                OP_LW: begin
                    exp_q.push_back(mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
                    for (int i = 0; i < nmem; i++)
                        exp_q.push_back(mk(3'd5, 0, 0, i == nmem - 1, 0, 1, 0, 0, 2'd0, 0));
                    exp_q.push_back(mk(3'd6, 1, 0, 0, 1, 0, 0, 1, 2'd0, 0));
                end
                OP_SW: begin
                    exp_q.push_back(mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0));
                    for (int i = 0; i < nmem; i++)
                        exp_q.push_back(mk(3'd5, i == nmem - 1, 0, 0, 0, 0, 1, 0, 2'd0, 0));
                end
                OP_BEQ: exp_q.push_back(mk(3'd3, 1, 0, 0, 0, 0, 0, 0, z ? 2'd1 : 2'd0, 0));
                OP_BNE: exp_q.push_back(mk(3'd3, 1, 0, 0, 0, 0, 0, 0, z ? 2'd0 : 2'd1, 0));
                default: begin // HALT: observe 20 cycles
                    for (int i = 0; i < 20; i++)
                        exp_q.push_back(mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));
                end
            endcase
        end
    endtask

    // Entered just after the posedge that starts IF; leaves just after the
    // posedge that ends the instruction.
    task automatic run_model(input string nm, input logic [5:0] op, input logic z, input int waits);
        int mem_i = 0;
        int pcw   = 0;
        int both  = 0;
        logic [12:0] act;
        bus.Opcode = op;
        bus.Zero   = z;
        build(op, z, waits);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k][12:10] == 3'd5) begin
`ifdef CTRL_MEM_WAIT_EN
                bus.MemReady = (mem_i == waits);
`else
                bus.MemReady = (waits > 0) ? 1'b0 : 1'($urandom % 2);
`endif
                mem_i++;
            end else begin
                bus.MemReady = 1'($urandom % 2);
            end
            @(negedge clk);
            act = get_out();
            chk($sformatf("%s_c%0d", nm, k), 32'(act), 32'(exp_q[k]));
            if (act[9]) pcw++;
            if (act[5] && act[4]) both++;
            @(posedge clk);
            #1;
        end
        if (op != OP_HALT) chk($sformatf("%s_pcwre_pulses", nm), pcw, 1);
        chk($sformatf("%s_mem_excl", nm), both, 0);
        bus.MemReady = 1'b1;
    endtask

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic       z;
        int         cyc;
        logic [1:0] psrc;
        logic       regw;
        logic       wsel;
    } row_t;

    row_t tbl[10];

    initial begin
        int cycles, pcw_cnt, both;
        logic [1:0] psrc_seen;
        logic regw_seen, wsel_seen;
        logic [5:0] rop;
        logic rz;
        int pick, waits;

        tbl[0] = '{"alu",      OP_ALU,    1'b0, 4, 2'd0, 1'b1, 1'b0};
        tbl[1] = '{"lw",       OP_LW,     1'b0, 5, 2'd0, 1'b1, 1'b1};
        tbl[2] = '{"sw",       OP_SW,     1'b0, 4, 2'd0, 1'b0, 1'b0};
        tbl[3] = '{"beq_z1",   OP_BEQ,    1'b1, 3, 2'd1, 1'b0, 1'b0};
        tbl[4] = '{"beq_z0",   OP_BEQ,    1'b0, 3, 2'd0, 1'b0, 1'b0};
        tbl[5] = '{"bne_z0",   OP_BNE,    1'b0, 3, 2'd1, 1'b0, 1'b0};
        tbl[6] = '{"bne_z1",   OP_BNE,    1'b1, 3, 2'd0, 1'b0, 1'b0};
        tbl[7] = '{"j",        OP_J,      1'b0, 2, 2'd2, 1'b0, 1'b0};
        tbl[8] = '{"nop_08",   6'b001000, 1'b0, 2, 2'd0, 1'b0, 1'b0};
        tbl[9] = '{"nop_3e",   6'b111110, 1'b1, 2, 2'd0, 1'b0, 1'b0};

        bus.Opcode   = 6'd0;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(get_out()), 32'd0);
        rst = 1'b1;
        #1;
        chk("reset_release_pre_edge", 32'(get_out()), 32'd0);
        @(posedge clk);
        #1;

        // Table rows: cycle count, PC source at the PC write, write-back behaviour
        for (int r = 0; r < 10; r++) begin
            bus.Opcode = tbl[r].op;
            bus.Zero   = tbl[r].z;
            cycles = 0; pcw_cnt = 0; both = 0;
            psrc_seen = 2'd3; regw_seen = 1'b0; wsel_seen = 1'b0;
            do begin
                @(negedge clk);
                cycles++;
                if (bus.PCWre) begin
                    pcw_cnt++;
                    psrc_seen = bus.PCSrc;
                end
                if (bus.RegWre) begin
                    regw_seen = 1'b1;
                    wsel_seen = bus.WrSel;
                end
                if (bus.MemRd && bus.MemWr) both++;
                @(posedge clk);
                #1;
            end while (bus.State != 3'd0 && cycles < 12);
            chk({tbl[r].nm, "_cycles"}, cycles, tbl[r].cyc);
            chk({tbl[r].nm, "_pcsrc"}, 32'(psrc_seen), 32'(tbl[r].psrc));
            chk({tbl[r].nm, "_regwre"}, 32'(regw_seen), 32'(tbl[r].regw));
            chk({tbl[r].nm, "_wrsel"}, 32'(wsel_seen), 32'(tbl[r].wsel));
            chk({tbl[r].nm, "_pcwre_pulses"}, pcw_cnt, 1);
            chk({tbl[r].nm, "_mem_excl"}, both, 0);
        end

        // Randomized instruction stream against the trace model
        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 7));
            rz   = 1'($urandom % 2);
            case (pick)
                1: rop = OP_LW;
                2: rop = OP_SW;
                3: rop = OP_BEQ;
                4: rop = OP_BNE;
                5: rop = OP_J;
                6: begin
                    rop = 6'($urandom);
                    if (rop == OP_ALU || rop == OP_LW || rop == OP_SW || rop == OP_BEQ ||
                        rop == OP_BNE || rop == OP_J || rop == OP_HALT)
                        rop = 6'b001000;
                end
                default: rop = OP_ALU;
            endcase
`ifdef CTRL_MEM_WAIT_EN
            waits = int'($urandom_range(0, 2));
`else
            waits = 0;
`endif
            run_model($sformatf("rnd%0d_op%02h", n, rop), rop, rz, waits);
        end

        // MEM wait states (or MemReady ignored when the feature is off)
`ifdef CTRL_MEM_WAIT_EN
        run_model("wait_lw3", OP_LW, 1'b0, 3);
        run_model("wait_sw2", OP_SW, 1'b0, 2);
`else
        run_model("memready_low_lw", OP_LW, 1'b0, 1);
        run_model("memready_low_sw", OP_SW, 1'b0, 1);
`endif

        // HALT holds for 20 observed cycles, only reset leaves it
        run_model("halt", OP_HALT, 1'b0, 0);
        bus.Opcode = OP_ALU;
        @(negedge clk);
        chk("halt_still_halted", 32'(get_out()), 32'(mk(3'd7, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1)));
        rst = 1'b0;
        #1;
        chk("rst_exits_halt", 32'(get_out()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted mid-EXE_LS of a LW
        bus.Opcode = OP_LW;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("exe_ls_before_rst", 32'(get_out()), 32'(mk(3'd4, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)));
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_mid_exe_ls", 32'(get_out()), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_held", 32'(get_out()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release_no_if_yet", 32'(get_out()), 32'd0);
        @(posedge clk);
        #1;
        bus.Opcode = OP_ALU;
        @(negedge clk);
        chk("first_if_after_rst", 32'(get_out()), 32'(mk(3'd0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 0)));
        @(posedge clk);
        #1;
        // Finish the ALU instruction already in flight (remaining ID, EXE_AL, WB)
        @(negedge clk);
        chk("post_rst_id", 32'(get_out()), 32'(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0)));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_wb", 32'(get_out()), 32'(mk(3'd6, 1, 0, 0, 1, 0, 0, 0, 2'd0, 0)));
        @(posedge clk);
        #1;
        run_model("post_rst_sw", OP_SW, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
